fsm_seq_ctrl: RTL and testbench

Initiator for the 4-state handshake sequencer (status codes 001/010/100/111 on a 3-bit `fsm_out`): accepts one command at a time, drives `start`, `step2`, `step3` with correct cycle alignment, and checks the returned status code every cycle. It sits between the host command interface and the sequencer instance. It reports completion, abort and protocol errors, and counts completed transactions.

---
 rtl/fsm_seq_pkg.sv | 44 ++++
 rtl/fsm_seq_ctrl_if.sv | 15 +
 rtl/fsm_seq_dwell_cnt.sv | 31 +++
 rtl/fsm_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_fsm_seq_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fsm_seq_pkg.sv
// fsm_seq_pkg: shared constants, controller state enum and helpers for the sequencer initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: status codes ST0..ST3, DW/CW defaults, ctrl_state_t, expected-code helpers.
// The C_ERR state only exists when FSM_SEQ_CHECK_EN is defined.
package fsm_seq_pkg;

  // Target status codes, one per target state.
  localparam logic [2:0] ST0 = 3'b001;
  localparam logic [2:0] ST1 = 3'b010;
  localparam logic [2:0] ST2 = 3'b100;
  localparam logic [2:0] ST3 = 3'b111;

  localparam int DW_DEF = 8;
  localparam int CW_DEF = 16;

  typedef enum logic [2:0] {
    C_IDLE,
    C_START,
    C_S1,
    C_S2,
    C_S3,
    C_END
`ifdef FSM_SEQ_CHECK_EN
    , C_ERR
`endif
  } ctrl_state_t;

  // States in which the target status code is checked.
  function automatic logic code_checked(ctrl_state_t s);
    return (s == C_S1) || (s == C_S2) || (s == C_S3) || (s == C_END);
  endfunction

  // Status code the target must present while the controller is in state s.
  function automatic logic [2:0] code_expected(ctrl_state_t s);
    case (s)
      C_S1:    return ST1;
      C_S2:    return ST2;
      C_S3:    return ST3;
      default: return ST0;
    endcase
  endfunction

endpackage

// File: rtl/fsm_seq_ctrl_if.sv
// fsm_seq_ctrl_if: host command bus of the sequencer initiator.
// Latency: n/a (wiring only).
// Backpressure: host holds cmd_valid and the command fields until cmd_ready is seen high.
// Ports: cmd_valid/cmd_abort/cmd_dwell from host (master), cmd_ready from controller (slave).
interface fsm_seq_ctrl_if #(
  parameter int DW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_abort;
  logic [DW-1:0] cmd_dwell;

  modport master (output cmd_valid, output cmd_abort, output cmd_dwell, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_abort, input cmd_dwell, output cmd_ready);
endinterface

// File: rtl/fsm_seq_dwell_cnt.sv
// fsm_seq_dwell_cnt: loadable DW-bit down-counter timing the state-3 dwell.
// Latency: last is combinational from the current load/dec request and count.
// Backpressure: none; load has priority over dec.
// Ports: clk, reset (async active-low), load/load_val, dec, last.
// last is the value the step3 drive should take next: a load of 0, or a decrement from 1.
module fsm_seq_dwell_cnt #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  input  logic          dec,
  output logic          last
);

  logic [DW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - DW'(1);
    end
  end

  assign last = load ? (load_val == '0) : (dec && (cnt == DW'(1)));

endmodule

// File: rtl/fsm_seq_ctrl.sv
// fsm_seq_ctrl: initiator for the 4-state handshake sequencer; drives start/step2/step3, checks fsm_out.
// Latency: done 6+dwell cycles after accept (5 when aborted); all drives and flags registered.
// Backpressure: cmd_ready only in idle; the host holds cmd_valid while busy. Next accept may coincide with done.
// Ports: clk, reset (async active-low), cmd (command bus, slave), start/step2/step3 to target,
//        fsm_out from target, done/aborted/err/err_clr, done_cnt.
// Build option FSM_SEQ_CHECK_EN: expected-code checking, sticky err and C_ERR; undefined = open loop.
module fsm_seq_ctrl
  import fsm_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  fsm_seq_ctrl_if.slave cmd,
  output logic          start,
  output logic          step2,
  output logic          step3,
  input  logic [2:0]    fsm_out,
  output logic          done,
  output logic          aborted,
  output logic          err,
  input  logic          err_clr,
  output logic [CW-1:0] done_cnt
);

  ctrl_state_t   state;
  logic          abort_q;
  logic [DW-1:0] dwell_q;
  logic          cmd_rdy;
  logic          cnt_load;
  logic          cnt_dec;
  logic          cnt_last;

`ifdef FSM_SEQ_CHECK_EN
  logic err_q;
  logic code_bad;

  assign code_bad = code_checked(state) && (fsm_out != code_expected(state));
  assign err      = err_q;
  // Accept only when the target reports idle, and never while reset is held.
  assign cmd_rdy  = reset && (state == C_IDLE) && (fsm_out == ST0);
`else
  // Open loop: the target status and the error clear play no part.
  logic unused_open_loop;

  assign unused_open_loop = ^{fsm_out, err_clr};
  assign err              = 1'b0;
  assign cmd_rdy          = reset && (state == C_IDLE);
`endif

  assign cmd.cmd_ready = cmd_rdy;

  // The dwell counter is loaded on the way into state 3 and counts down while step3 is still low.
  assign cnt_load = (state == C_S2) && !abort_q;
  assign cnt_dec  = (state == C_S3) && !step3;

  fsm_seq_dwell_cnt #(.DW(DW)) u_dwell_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (dwell_q),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= C_IDLE;
      abort_q  <= 1'b0;
      dwell_q  <= '0;
      start    <= 1'b0;
      step2    <= 1'b0;
      step3    <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      done_cnt <= '0;
`ifdef FSM_SEQ_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
`ifdef FSM_SEQ_CHECK_EN
      // A wrong status code anywhere in the sequence drops every drive and parks in C_ERR.
      if (code_bad) begin
        start <= 1'b0;
        step2 <= 1'b0;
        step3 <= 1'b0;
        err_q <= 1'b1;
        state <= C_ERR;
      end else
`endif
      case (state)
        C_IDLE: begin
          if (cmd.cmd_valid && cmd_rdy) begin
            abort_q <= cmd.cmd_abort;
            dwell_q <= cmd.cmd_dwell;
            start   <= 1'b1;
            state   <= C_START;
          end
        end
        C_START: begin
          start <= 1'b0;
          state <= C_S1;
        end
        C_S1: begin
          // Withholding step2 is what sends the target from state 2 back to idle.
          step2 <= ~abort_q;
          state <= C_S2;
        end
        C_S2: begin
          step2 <= 1'b0;
          if (abort_q) begin
            state <= C_END;
          end else begin
            step3 <= cnt_last;
            state <= C_S3;
          end
        end
        C_S3: begin
          if (step3) begin
            step3 <= 1'b0;
            state <= C_END;
          end else begin
            step3 <= cnt_last;
          end
        end
        C_END: begin
          done    <= 1'b1;
          aborted <= abort_q;
          if (!abort_q) begin
            done_cnt <= done_cnt + CW'(1);
          end
          state <= C_IDLE;
        end
`ifdef FSM_SEQ_CHECK_EN
        C_ERR: begin
          if (err_clr) begin
            err_q <= 1'b0;
            state <= C_IDLE;
          end
        end
`endif
        default: begin
          state <= C_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// tb_fsm_seq_ctrl: self-checking bench for fsm_seq_ctrl driving a behavioural sequencer target.
// Latency: n/a.
// Backpressure: host side holds cmd_valid until cmd_ready; next command may start in the done cycle.
// Expected drive waveforms are computed per cycle from the command (abort, dwell) with plain arithmetic.
// Build option FSM_SEQ_CHECK_EN selects the error-recovery scenario; otherwise the stuck-status open-loop one.
module tb_fsm_seq_ctrl;

  localparam int DW      = 8;
  localparam int CW      = 4;
  localparam int CNT_MOD = 1 << CW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, step2, step3;
  logic          done, aborted, err, err_clr;
  logic [2:0]    fsm_out;
  logic [CW-1:0] done_cnt;

  fsm_seq_ctrl_if #(.DW(DW)) cmd_bus ();

  // Behavioural target: 0 idle, 1 state1, 2 state2, 3 state3.
  logic [1:0] tgt;
  logic       force_en;
  logic [2:0] force_code;
  logic       tgt_clear;

  int checks    = 0;
  int passes    = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  fsm_seq_ctrl #(.DW(DW), .CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd      (cmd_bus),
    .start    (start),
    .step2    (step2),
    .step3    (step3),
    .fsm_out  (fsm_out),
    .done     (done),
    .aborted  (aborted),
    .err      (err),
    .err_clr  (err_clr),
    .done_cnt (done_cnt)
  );

  function automatic logic [2:0] tgt_code(logic [1:0] s);
    case (s)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b111;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      tgt <= 2'd0;
    end else if (tgt_clear) begin
      tgt <= 2'd0;
    end else begin
      case (tgt)
        2'd0:    if (start) tgt <= 2'd1;
        2'd1:    tgt <= 2'd2;
        2'd2:    tgt <= step2 ? 2'd3 : 2'd0;
        default: if (step3) tgt <= 2'd0;
      endcase
    end
  end

  assign fsm_out = force_en ? force_code : tgt_code(tgt);

  // Issue one command and check every cycle up to and including its done cycle.
  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_cmd(input logic ab, input logic [DW-1:0] dw, input string tag);
    int         kend;
    int         st3_cycles;
    int         w;
    logic [6:0] got;
    logic [6:0] want;
    kend       = ab ? 5 : 6 + int'(dw);
    st3_cycles = 0;
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_abort = ab;
    cmd_bus.cmd_dwell = dw;
    w = 0;
    while (cmd_bus.cmd_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (cmd_bus.cmd_ready !== 1'b1) begin
      $display("FAIL %s accept: cmd_ready=%b want=1 after %0d cycles", tag, cmd_bus.cmd_ready, w);
      cmd_bus.cmd_valid = 1'b0;
      return;
    end
    passes++;
    @(negedge clk);
    // Scramble the fields once accepted; the controller must have latched them.
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_abort = ~ab;
    cmd_bus.cmd_dwell = DW'($urandom);
    for (int k = 1; k <= kend; k++) begin
      if (k > 1) @(negedge clk);
      if (fsm_out === 3'b111) st3_cycles++;
      want[6] = (k == 1);
      want[5] = !ab && (k == 3);
      want[4] = !ab && (k == 4 + int'(dw));
      want[3] = (k == kend);
      want[2] = ab && (k == kend);
      want[1] = 1'b0;
      want[0] = (k == kend);
      got = {start, step2, step3, done, aborted, err, cmd_bus.cmd_ready};
      checks++;
      if (got !== want)
        $display("FAIL %s cycle%0d {start,step2,step3,done,aborted,err,ready} got=%b want=%b",
                 tag, k, got, want);
      else
        passes++;
      if (k == kend && !ab) model_cnt = (model_cnt + 1) % CNT_MOD;
      checks++;
      if (done_cnt !== CW'(model_cnt))
        $display("FAIL %s cycle%0d done_cnt got=%0d want=%0d", tag, k, done_cnt, model_cnt);
      else
        passes++;
    end
    if (!force_en) begin
      checks++;
      if (st3_cycles != (ab ? 0 : int'(dw) + 1))
        $display("FAIL %s state3_cycles got=%0d want=%0d", tag, st3_cycles, ab ? 0 : int'(dw) + 1);
      else
        passes++;
    end
  endtask

  task automatic test_reset();
    reset             = 1'b0;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_abort = 1'b0;
    cmd_bus.cmd_dwell = '0;
    err_clr           = 1'b0;
    force_en          = 1'b0;
    force_code        = 3'b000;
    tgt_clear         = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({start, step2, step3, done, aborted, err, cmd_bus.cmd_ready} !== 7'b0)
      $display("FAIL reset_outputs got=%b want=0000000",
               {start, step2, step3, done, aborted, err, cmd_bus.cmd_ready});
    else
      passes++;
    checks++;
    if (done_cnt !== '0) $display("FAIL reset_done_cnt got=%0d want=0", done_cnt);
    else passes++;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_bus.cmd_ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", cmd_bus.cmd_ready);
    else passes++;
  endtask

  task automatic test_dwell0();
    run_cmd(1'b0, 8'd0, "dwell0");
  endtask

  task automatic test_dwell5();
    run_cmd(1'b0, 8'd5, "dwell5");
  endtask

  task automatic test_abort();
    run_cmd(1'b1, DW'($urandom_range(0, 20)), "abort");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++)
      run_cmd(($urandom % 4) == 0, DW'($urandom_range(0, 12)), "b2b");
  endtask

  task automatic test_max_dwell();
    run_cmd(1'b0, {DW{1'b1}}, "max_dwell");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < CNT_MOD && model_cnt != CNT_MOD - 1; i++)
      run_cmd(1'b0, DW'($urandom_range(0, 3)), "wrap_fill");
    checks++;
    if (done_cnt !== {CW{1'b1}}) $display("FAIL wrap_preload done_cnt got=%0d want=%0d", done_cnt, CNT_MOD - 1);
    else passes++;
    run_cmd(1'b0, 8'd1, "wrap");
    checks++;
    if (done_cnt !== '0) $display("FAIL wrap done_cnt got=%0d want=0", done_cnt);
    else passes++;
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_abort = 1'b0;
    cmd_bus.cmd_dwell = '0;
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (step3 !== 1'b1) $display("FAIL mid_reset_pre step3 got=%b want=1", step3);
    else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if ({start, step2, step3, done, aborted, err, cmd_bus.cmd_ready} !== 7'b0)
      $display("FAIL mid_reset_outputs got=%b want=0000000",
               {start, step2, step3, done, aborted, err, cmd_bus.cmd_ready});
    else
      passes++;
    checks++;
    if (done_cnt !== '0) $display("FAIL mid_reset_done_cnt got=%0d want=0", done_cnt);
    else passes++;
    model_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_bus.cmd_ready !== 1'b1) $display("FAIL mid_reset_ready got=%b want=1", cmd_bus.cmd_ready);
    else passes++;
    run_cmd(1'b0, 8'd2, "after_reset");
  endtask

`ifdef FSM_SEQ_CHECK_EN
  task automatic test_error();
    int seen_done;
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_abort = 1'b0;
    cmd_bus.cmd_dwell = 8'd3;
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    force_code = 3'b001;
    force_en   = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({start, step2, step3, done, err, cmd_bus.cmd_ready} !== 6'b000010)
      $display("FAIL error_entry {start,step2,step3,done,err,ready} got=%b want=000010",
               {start, step2, step3, done, err, cmd_bus.cmd_ready});
    else
      passes++;
    force_en  = 1'b0;
    tgt_clear = 1'b1;
    @(negedge clk);
    tgt_clear = 1'b0;
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0 || err !== 1'b1 || cmd_bus.cmd_ready !== 1'b0)
      $display("FAIL error_hold done_seen=%0d err=%b ready=%b want 0/1/0", seen_done, err, cmd_bus.cmd_ready);
    else
      passes++;
    checks++;
    if (done_cnt !== CW'(model_cnt)) $display("FAIL error_count done_cnt got=%0d want=%0d", done_cnt, model_cnt);
    else passes++;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0 || cmd_bus.cmd_ready !== 1'b1)
      $display("FAIL error_clear err=%b ready=%b want 0/1", err, cmd_bus.cmd_ready);
    else
      passes++;
    run_cmd(1'b0, 8'd4, "after_err");
  endtask
`else
  task automatic test_open_loop();
    force_code = 3'b000;
    force_en   = 1'b1;
    run_cmd(1'b0, DW'($urandom_range(0, 9)), "stuck_status");
    run_cmd(1'b1, DW'($urandom_range(0, 9)), "stuck_status_abort");
    force_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_dwell0();
    test_dwell5();
    test_abort();
    test_back_to_back();
    test_max_dwell();
    test_wrap();
    test_mid_reset();
`ifdef FSM_SEQ_CHECK_EN
    test_error();
`else
    test_open_loop();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
